// File: rtl/hart_run_ctrl.sv
// Per-hart run control: sequences hart reset, halt and resume handshakes with the core
// and reports run/halt/reset status back to the debug module.
module hart_run_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned HALT_TIMEOUT = 1023
) (
  input  logic CLK100M,
  input  logic TRST_N,
  input  logic HALTREQ,
  input  logic RESUMEREQ,
  input  logic HARTRESET,
  input  logic NDMRESET,
  input  logic ACKHAVERESET,
  input  logic ERR_CLR,
  input  logic CPU_HALTED,
  output logic CPU_HALT_O,
  output logic CPU_RESUME_O,
  output logic CPU_RESET_O,
  output logic RUNNING,
  output logic HALTED,
  output logic RESUMEACK,
  output logic HAVERESET,
  output logic HALT_ERR
);

  typedef enum logic [2:0] {
    ST_RESET, ST_RUN, ST_HALTING, ST_HALTED, ST_RESUMING, ST_ACK
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] HALT_TO  = 16'(HALT_TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        reset_req, err_set;
  logic        halt_o_next, resume_o_next, reset_o_next, running_next;
  logic        halted_next, resumeack_next, havereset_next, halt_err_next;

  assign reset_req = HARTRESET | NDMRESET;

  // Outputs are registered from the next-state decode so they change together with the state.
  always_ff @(posedge CLK100M or negedge TRST_N) begin
    if (!TRST_N) begin
      state_reg    <= ST_RESET;
      cnt_reg      <= '0;
      CPU_HALT_O   <= 1'b0;
      CPU_RESUME_O <= 1'b0;
      CPU_RESET_O  <= 1'b1;
      RUNNING      <= 1'b0;
      HALTED       <= 1'b0;
      RESUMEACK    <= 1'b0;
      HAVERESET    <= 1'b1;
      HALT_ERR     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      CPU_HALT_O   <= halt_o_next;
      CPU_RESUME_O <= resume_o_next;
      CPU_RESET_O  <= reset_o_next;
      RUNNING      <= running_next;
      HALTED       <= halted_next;
      RESUMEACK    <= resumeack_next;
      HAVERESET    <= havereset_next;
      HALT_ERR     <= halt_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    case (state_reg)
      ST_RESET:
        if (cnt_reg >= RST_LAST) state_next = HALTREQ ? ST_HALTING : ST_RUN;
      ST_RUN:
        if (HALTREQ && !HALT_ERR) state_next = ST_HALTING;
      ST_HALTING:
        if (CPU_HALTED) begin
          state_next = ST_HALTED;
        end else if (cnt_reg >= HALT_TO) begin
          state_next = ST_RUN;
          err_set    = 1'b1;
        end
      ST_HALTED:
        if (RESUMEREQ && !HALTREQ) state_next = ST_RESUMING;
      ST_RESUMING:
        if (!CPU_HALTED) begin
          state_next = ST_ACK;
        end else if (cnt_reg >= HALT_TO) begin
          state_next = ST_HALTED;
          err_set    = 1'b1;
        end
      ST_ACK:
        if (HALTREQ) state_next = ST_HALTING;
        else if (!RESUMEREQ) state_next = ST_RUN;
      default:
        state_next = ST_RESET;
    endcase
    if (reset_req) begin
      state_next = ST_RESET;
      err_set    = 1'b0;
    end
  end

  always_comb begin
    // A held reset request keeps the count at zero so the reset pulse is measured from its release.
    if (reset_req || state_next != state_reg) cnt_next = '0;
    else if (cnt_reg != 16'hFFFF)             cnt_next = cnt_reg + 16'd1;
    else                                      cnt_next = cnt_reg;

    halt_o_next    = (state_next == ST_HALTING) || (state_next == ST_HALTED);
    resume_o_next  = (state_next == ST_RESUMING) && (state_reg != ST_RESUMING);
    reset_o_next   = (state_next == ST_RESET);
    running_next   = (state_next == ST_RUN) || (state_next == ST_ACK);
    halted_next    = (state_next == ST_HALTED);
    resumeack_next = (state_next == ST_ACK);

    if (state_next == ST_RESET) havereset_next = 1'b1;
    else if (ACKHAVERESET)      havereset_next = 1'b0;
    else                        havereset_next = HAVERESET;

    if (err_set)      halt_err_next = 1'b1;
    else if (ERR_CLR) halt_err_next = 1'b0;
    else              halt_err_next = HALT_ERR;
  end

endmodule
